ptcalc_pipe_mul_rs: RTL and testbench

- Parametrised, pipelined signed multiplier for the ptcalc datapath. Successor to the fixed 24x12->38 combinational DSP multiplier.
- Adds the following over that block:
  - a configurable pipeline depth;
  - valid/ready flow control;
  - a post-multiply arithmetic right shift with optional round-half-up;
  - saturation to the output width;
  - a sticky overflow counter for monitoring.
- Sits between ptcalc HLS stages wherever a scaled product must be narrowed without silent wrap.

---
 rtl/ptcalc_pipe_mul_rs.sv | 187 ++++++++++++++++++
 tb/tb_ptcalc_pipe_mul_rs.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptcalc_pipe_mul_rs.sv
// Pipelined signed multiplier with valid/ready flow control, scaled narrowing,
// saturation and a sticky overflow counter for the ptcalc datapath.
module ptcalc_pipe_mul_rs #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 24,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 38,
  parameter int SHIFT      = 0,
  parameter int ROUND      = 0,
  parameter int SAT        = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dout_ovf,
  output logic [CNT_WIDTH-1:0]  ovf_cnt,
  input  logic                  ovf_clr
);

  localparam int W  = din0_WIDTH + din1_WIDTH;
  localparam int XW = (W + 1 > dout_WIDTH) ? W + 1 : dout_WIDTH;

  typedef logic signed [W-1:0]  prod_t;
  typedef logic signed [W:0]    wide_t;
  typedef logic signed [XW-1:0] xw_t;
  typedef logic [dout_WIDTH-1:0] dout_t;

  localparam int    RSH  = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam wide_t RND  = (ROUND != 0 && SHIFT > 0) ?
                           (wide_t'(1) <<< RSH) : wide_t'(0);
  localparam xw_t   MAXX = (xw_t'(1) <<< (dout_WIDTH - 1)) - xw_t'(1);
  localparam xw_t   MINX = -(xw_t'(1) <<< (dout_WIDTH - 1));

  if (NUM_STAGE < 1 || NUM_STAGE > 6 || SHIFT < 0 || SHIFT >= W ||
      ID < 0) begin : g_bad_param
    $error("ptcalc_pipe_mul_rs: illegal parameter set");
  end

  function automatic prod_t prod(input logic [din0_WIDTH-1:0] a,
                                 input logic [din1_WIDTH-1:0] b);
    return prod_t'($signed(a)) * prod_t'($signed(b));
  endfunction

  // One extra bit keeps the rounding add from wrapping before the shift.
  function automatic logic [dout_WIDTH:0] narrow(input prod_t p);
    wide_t s;
    xw_t   r;
    logic  ovf;
    dout_t d;
    s   = (wide_t'(p) + RND) >>> SHIFT;
    r   = xw_t'(s);
    ovf = (r > MAXX) || (r < MINX);
    d   = dout_t'(r);
    if (ovf && SAT != 0) begin
      d = r[XW-1] ? dout_t'(MINX) : dout_t'(MAXX);
    end
    return {ovf, d};
  endfunction

  logic                 adv;
  logic [NUM_STAGE-1:0] vld_q, vld_d;
  prod_t                fin_p;

  assign out_valid = vld_q[NUM_STAGE-1];
  assign adv       = !(out_valid && !out_ready);
  assign in_ready  = adv;

  always_comb begin
    vld_d = vld_q;
    if (adv) begin
      vld_d[0] = in_valid;
      for (int i = 1; i < NUM_STAGE; i++) begin
        vld_d[i] = vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_q <= '0;
    else       vld_q <= vld_d;
  end

  if (NUM_STAGE == 1) begin : g_s1
    assign fin_p = prod(din0, din1);
  end else if (NUM_STAGE == 2) begin : g_s2
    prod_t p_q, p_d;

    always_comb begin
      p_d = p_q;
      if (adv) p_d = prod(din0, din1);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) p_q <= '0;
      else       p_q <= p_d;
    end

    assign fin_p = p_q;
  end else begin : g_sn
    localparam int NP = NUM_STAGE - 2;
    logic [din0_WIDTH-1:0] a_q, a_d;
    logic [din1_WIDTH-1:0] b_q, b_d;
    prod_t                 p_q [NP];
    prod_t                 p_d [NP];

    // Operands registered first; trailing product stages give DSP retiming room.
    always_comb begin
      a_d = a_q;
      b_d = b_q;
      p_d = p_q;
      if (adv) begin
        a_d    = din0;
        b_d    = din1;
        p_d[0] = prod(a_q, b_q);
        for (int i = 1; i < NP; i++) begin
          p_d[i] = p_q[i-1];
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        a_q <= '0;
        b_q <= '0;
        for (int i = 0; i < NP; i++) begin
          p_q[i] <= '0;
        end
      end else begin
        a_q <= a_d;
        b_q <= b_d;
        p_q <= p_d;
      end
    end

    assign fin_p = p_q[NP-1];
  end

  logic [dout_WIDTH:0]  nar;
  dout_t                res_q, res_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign nar = narrow(fin_p);

  always_comb begin
    res_d = res_q;
    ovf_d = ovf_q;
    if (adv) begin
      ovf_d = nar[dout_WIDTH];
      res_d = nar[dout_WIDTH-1:0];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ovf_clr) begin
      cnt_d = '0;
    end else if (out_valid && out_ready && ovf_q && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      res_q <= res_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout     = res_q;
  assign dout_ovf = ovf_q;
  assign ovf_cnt  = cnt_q;

endmodule

// File: tb/tb_ptcalc_pipe_mul_rs.sv
// Bench for ptcalc_pipe_mul_rs: four parameter variants share one stimulus
// stream and are checked against an arithmetic reference model.
module tb_ptcalc_pipe_mul_rs;

  typedef struct {
    logic signed [63:0] d;
    logic               o;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        ovf_clr = 1'b0;
  logic [23:0] din0 = '0;
  logic [11:0] din1 = '0;

  logic [3:0]  rdy, ov, of;
  logic [37:0] d0;
  logic [15:0] d1, d2, d3;
  logic [15:0] c0, c1, c3;
  logic [1:0]  c2;

  int total = 0;
  int bad = 0;
  exp_t q [4][$];
  logic signed [63:0] last_d [4];
  logic               last_o [4];
  logic signed [63:0] mcnt [4];
  int                 nhand [4];

  always #5 clk = ~clk;

  // 0: defaults, 1: round+sat 16b, 2: sat 16b 2-bit counter, 3: wrap 16b
  ptcalc_pipe_mul_rs u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
    .din0(din0), .din1(din1), .out_valid(ov[0]), .out_ready(out_ready),
    .dout(d0), .dout_ovf(of[0]), .ovf_cnt(c0), .ovf_clr(ovf_clr));

  ptcalc_pipe_mul_rs #(.NUM_STAGE(2), .dout_WIDTH(16), .SHIFT(4),
                       .ROUND(1), .SAT(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
    .din0(din0), .din1(din1), .out_valid(ov[1]), .out_ready(out_ready),
    .dout(d1), .dout_ovf(of[1]), .ovf_cnt(c1), .ovf_clr(ovf_clr));

  ptcalc_pipe_mul_rs #(.NUM_STAGE(1), .dout_WIDTH(16), .SHIFT(4),
                       .SAT(1), .CNT_WIDTH(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]),
    .din0(din0), .din1(din1), .out_valid(ov[2]), .out_ready(out_ready),
    .dout(d2), .dout_ovf(of[2]), .ovf_cnt(c2), .ovf_clr(ovf_clr));

  ptcalc_pipe_mul_rs #(.NUM_STAGE(5), .dout_WIDTH(16), .SHIFT(4),
                       .SAT(0)) u3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[3]),
    .din0(din0), .din1(din1), .out_valid(ov[3]), .out_ready(out_ready),
    .dout(d3), .dout_ovf(of[3]), .ovf_cnt(c3), .ovf_clr(ovf_clr));

  function automatic exp_t model(int k, logic [23:0] a, logic [11:0] b);
    exp_t  e;
    longint p, r, mx, mn;
    int    sh, dw;
    bit    rnd, sat;
    sh = (k == 0) ? 0 : 4;
    dw = (k == 0) ? 38 : 16;
    rnd = (k == 1);
    sat = (k != 3);
    p = longint'($signed(a)) * longint'($signed(b));
    r = p;
    if (rnd && sh > 0) r = r + (longint'(1) <<< (sh - 1));
    r = r >>> sh;
    mx = (longint'(1) <<< (dw - 1)) - 1;
    mn = -mx - 1;
    if (r > mx || r < mn) begin
      e.o = 1'b1;
      if (sat) e.d = (r > mx) ? mx : mn;
      else     e.d = (r <<< (64 - dw)) >>> (64 - dw);
    end else begin
      e.o = 1'b0;
      e.d = r;
    end
    return e;
  endfunction

  function automatic longint cmax(int k);
    return (k == 2) ? 3 : 65535;
  endfunction

  task automatic chk(string tag, logic signed [63:0] got,
                     logic signed [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic mon(int k, logic rdy_k, logic ov_k,
                     logic signed [63:0] d, logic o,
                     logic signed [63:0] c);
    exp_t e;
    if (reset) begin
      q[k].delete();
      mcnt[k] = 0;
      chk($sformatf("rst_out_valid%0d", k), 64'(ov_k), 64'sd0);
      return;
    end
    chk($sformatf("ovf_cnt%0d", k), c, mcnt[k]);
    if (ov_k && out_ready) begin
      if (q[k].size() > 0) begin
        e = q[k].pop_front();
      end else begin
        e.d = 'x;
        e.o = 1'bx;
      end
      chk($sformatf("dout%0d", k), d, e.d);
      chk($sformatf("dout_ovf%0d", k), 64'(o), 64'(e.o));
      last_d[k] = d;
      last_o[k] = o;
      nhand[k]++;
      if (ovf_clr) mcnt[k] = 0;
      else if (e.o === 1'b1 && mcnt[k] < cmax(k)) mcnt[k]++;
    end else if (ovf_clr) begin
      mcnt[k] = 0;
    end
    if (in_valid && rdy_k) q[k].push_back(model(k, din0, din1));
  endtask

  always @(negedge clk) mon(0, rdy[0], ov[0], 64'($signed(d0)), of[0], 64'(c0));
  always @(negedge clk) mon(1, rdy[1], ov[1], 64'($signed(d1)), of[1], 64'(c1));
  always @(negedge clk) mon(2, rdy[2], ov[2], 64'($signed(d2)), of[2], 64'(c2));
  always @(negedge clk) mon(3, rdy[3], ov[3], 64'($signed(d3)), of[3], 64'(c3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [23:0] a, logic [11:0] b);
    din0 = a;
    din1 = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (8) tick();
  endtask

  task automatic clr();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
  endtask

  initial begin
    int lat [4];
    int nh, vcnt;
    logic [37:0] h0;
    logic [15:0] h3;
    for (int k = 0; k < 4; k++) begin
      nhand[k] = 0;
      mcnt[k] = 0;
      lat[k] = 0;
    end

    #1 reset = 1'b1;
    repeat (2) tick();
    chk("reset_out_valid", 64'(ov), 64'sd0);
    chk("reset_dout", 64'(d0), 64'sd0);
    chk("reset_ovf", 64'(of), 64'sd0);
    chk("reset_cnt", 64'(c0), 64'sd0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 64'(rdy), 64'sd15);
    tick();

    send(24'h800000, 12'h800);
    for (int c = 1; c <= 8; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (ov[k] && lat[k] == 0) lat[k] = c;
      end
      tick();
    end
    chk("latency0", 64'(lat[0]), 64'sd3);
    chk("latency1", 64'(lat[1]), 64'sd2);
    chk("latency2", 64'(lat[2]), 64'sd1);
    chk("latency3", 64'(lat[3]), 64'sd5);
    chk("min_x_min", last_d[0], 64'sd17179869184);
    chk("min_x_min_ovf", 64'(last_o[0]), 64'sd0);

    nh = nhand[0];
    vcnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (i >= 3) vcnt += int'(ov[0]);
      din0 = 24'($urandom);
      din1 = 12'($urandom);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    drain();
    chk("stream_count", 64'(nhand[0] - nh), 64'sd100);
    chk("stream_rate", 64'(vcnt), 64'sd97);

    clr();
    send(24'd1000, 12'd100);
    drain();
    chk("rnd_1000x100", last_d[1], 64'sd6250);
    send(24'd7, 12'd3);
    drain();
    chk("rnd_7x3", last_d[1], 64'sd1);
    send(-24'sd7, 12'd3);
    drain();
    chk("rnd_m7x3", last_d[1], -64'sd1);
    send(24'd8, 12'd1);
    drain();
    chk("rnd_half_pos", last_d[1], 64'sd1);
    send(-24'sd8, 12'd1);
    drain();
    chk("rnd_half_neg", last_d[1], 64'sd0);

    clr();
    send(24'd8388607, 12'd2047);
    drain();
    chk("sat_pos", last_d[1], 64'sd32767);
    chk("sat_pos_ovf", 64'(last_o[1]), 64'sd1);
    chk("wrap_pos", last_d[3], -64'sd128);
    chk("wrap_pos_ovf", 64'(last_o[3]), 64'sd1);
    send(24'h800000, 12'd2047);
    drain();
    chk("sat_neg", last_d[1], -64'sd32768);
    chk("sat_neg_ovf", 64'(last_o[1]), 64'sd1);
    chk("wrap_neg", last_d[3], 64'sd0);
    chk("wrap_neg_ovf", 64'(last_o[3]), 64'sd1);
    chk("ovf_cnt_two", 64'(c1), 64'sd2);

    clr();
    for (int i = 0; i < 5; i++) begin
      send(24'd8388607, 12'd2047);
    end
    drain();
    chk("cnt_sticky", 64'(c2), 64'sd3);
    chk("cnt_five", 64'(c1), 64'sd5);

    send(24'd8388607, 12'd2047);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_priority", 64'(c2), 64'sd0);
    drain();

    for (int i = 0; i < 40; i++) begin
      din0 = 24'($urandom);
      din1 = 12'($urandom);
      in_valid = 1'b1;
      if (i == 15) begin
        out_ready = 1'b0;
        #1;
        h0 = d0;
        h3 = d3;
      end
      if (i >= 15 && i < 20) begin
        chk("stall_ready0", 64'(rdy[0]), 64'sd0);
        chk("stall_ready3", 64'(rdy[3]), 64'sd0);
        chk("stall_hold0", 64'(d0), 64'(h0));
        chk("stall_hold3", 64'(d3), 64'(h3));
      end
      if (i == 20) out_ready = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    drain();

    for (int i = 0; i < 300; i++) begin
      din0 = 24'($urandom);
      din1 = 12'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    ovf_clr = 1'b0;
    drain();

    nh = nhand[0];
    for (int i = 0; i < 3; i++) begin
      din0 = 24'($urandom);
      din1 = 12'($urandom);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_reset_valid", 64'(ov), 64'sd0);
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("ready_after_midreset", 64'(rdy), 64'sd15);
    repeat (10) tick();
    chk("no_stale_out", 64'(nhand[0] - nh), 64'sd0);
    chk("cnt_after_reset", 64'(c1), 64'sd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
